// File: rtl/contador_updown.sv
// Synchronous modulo-MODULO up/down counter with parallel load, terminal count
// for cascading, and a one-cycle error pulse when a load value is out of range.
module contador_updown #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             err
);

  // One extra bit so MODULO = 2**WIDTH is representable for the range check.
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_C  = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH - 1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qn_r;
  logic             err_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             err_nxt_s;
  logic             load_ok_s;
  logic             tc_s;

  // Next-state selection: load has priority over counting, counting over hold.
  always_comb begin
    q_nxt_s   = q_r;
    err_nxt_s = 1'b0;
    load_ok_s = ({1'b0, d} < MOD_C);
    if (load) begin
      if (load_ok_s) begin
        q_nxt_s = d;
      end else begin
        q_nxt_s   = q_r;
        err_nxt_s = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        q_nxt_s = (q_r == MAX_C) ? ZERO_C : (q_r + ONE_C);
      end else begin
        q_nxt_s = (q_r == ZERO_C) ? MAX_C : (q_r - ONE_C);
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Terminal count is high the cycle before the wrap edge.
  always_comb begin
    tc_s = en & ~load & ((up & (q_r == MAX_C)) | (~up & (q_r == ZERO_C)));
  end

  // Count, complement and error registers; complement kept as its own flops.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q_r   <= ZERO_C;
      qn_r  <= {WIDTH{1'b1}};
      err_r <= 1'b0;
    end else begin
      q_r   <= q_nxt_s;
      qn_r  <= ~q_nxt_s;
      err_r <= err_nxt_s;
    end
  end

  assign q   = q_r;
  assign qn  = qn_r;
  assign tc  = tc_s;
  assign err = err_r;

endmodule

// File: tb/tb_contador_updown.sv
// Directed bench for contador_updown: an arithmetic reference model checked every
// cycle, plus literal expectations for reset, wrap, load range, 2**WIDTH and cascade.
module tb_contador_updown;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       en = 1'b0, up = 1'b0, load = 1'b0;
  logic [3:0] d = 4'd0;
  logic       en_c = 1'b0;

  logic [3:0] q, qn, q16, qn16, q_lo, qn_lo, q_hi, qn_hi;
  logic       tc, err, tc16, err16, tc_lo, err_lo, tc_hi, err_hi;

  int n_cmp = 0;
  int n_bad = 0;

  int m_q, m_err, m16_q, m16_err, m_c;

  always #5 clk = ~clk;

  contador_updown #(.WIDTH(4), .MODULO(10)) dut (
    .clk(clk), .clrn(clrn), .en(en), .up(up), .load(load), .d(d),
    .q(q), .qn(qn), .tc(tc), .err(err));

  contador_updown #(.WIDTH(4), .MODULO(16)) dut16 (
    .clk(clk), .clrn(clrn), .en(en), .up(up), .load(load), .d(d),
    .q(q16), .qn(qn16), .tc(tc16), .err(err16));

  contador_updown #(.WIDTH(4), .MODULO(10)) u_lo (
    .clk(clk), .clrn(clrn), .en(en_c), .up(1'b1), .load(1'b0), .d(4'd0),
    .q(q_lo), .qn(qn_lo), .tc(tc_lo), .err(err_lo));

  contador_updown #(.WIDTH(4), .MODULO(10)) u_hi (
    .clk(clk), .clrn(clrn), .en(tc_lo), .up(1'b1), .load(1'b0), .d(4'd0),
    .q(q_hi), .qn(qn_hi), .tc(tc_hi), .err(err_hi));

  function automatic int nxt(int cur, int m, bit ld, bit e, bit u, int dv);
    if (ld) return (dv < m) ? dv : cur;
    if (e) return u ? (cur + 1) % m : (cur + m - 1) % m;
    return cur;
  endfunction

  function automatic int tcx(int cur, int m, bit ld, bit e, bit u);
    return (e && !ld && (u ? (cur == m - 1) : (cur == 0))) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the counters as plain integers modulo their range.
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_q <= 0; m_err <= 0; m16_q <= 0; m16_err <= 0; m_c <= 0;
    end else begin
      m_q     <= nxt(m_q, 10, load, en, up, int'(d));
      m_err   <= (load && int'(d) >= 10) ? 1 : 0;
      m16_q   <= nxt(m16_q, 16, load, en, up, int'(d));
      m16_err <= 0;
      if (en_c) m_c <= (m_c + 1) % 100;
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    check("m_q", int'(q), m_q);
    check("m_qn", int'(qn), 15 - m_q);
    check("m_tc", int'(tc), tcx(m_q, 10, load, en, up));
    check("m_err", int'(err), m_err);
    check("m16_q", int'(q16), m16_q);
    check("m16_qn", int'(qn16), 15 - m16_q);
    check("m16_tc", int'(tc16), tcx(m16_q, 16, load, en, up));
    check("m16_err", int'(err16), m16_err);
    check("c_lo", int'(q_lo), m_c % 10);
    check("c_hi", int'(q_hi), m_c / 10);
    check("c_tc_lo", int'(tc_lo), (en_c && (m_c % 10) == 9) ? 1 : 0);
    check("c_tc_hi", int'(tc_hi), (en_c && m_c == 99) ? 1 : 0);
  end

  // Apply inputs, then let one rising edge pass; returns at negedge + 1.
  task automatic cyc(input bit ld, input bit e, input bit u, input int dv);
    load = ld; en = e; up = u; d = 4'(dv);
    @(negedge clk); #1;
  endtask

  initial begin
    @(negedge clk); #1;
    check("rst_q", int'(q), 0);
    check("rst_qn", int'(qn), 15);
    clrn = 1'b1;
    cyc(0, 0, 0, 0);
    check("idle_q", int'(q), 0);

    // Reset between edges clears q and a pending err, with no edge needed.
    cyc(1, 0, 0, 7);
    check("ld7_q", int'(q), 7);
    cyc(1, 0, 0, 12);
    check("ld12_hold", int'(q), 7);
    check("ld12_err", int'(err), 1);
    check("ld12_q16", int'(q16), 12);
    load = 1'b1; d = 4'd5;
    #2 clrn = 1'b0;
    #1;
    check("arst_q", int'(q), 0);
    check("arst_qn", int'(qn), 15);
    check("arst_err", int'(err), 0);
    check("arst_tc", int'(tc), 0);
    @(negedge clk); #1;
    load = 1'b0; d = 4'd0; clrn = 1'b1;
    cyc(0, 0, 0, 0);
    check("post_rst_q", int'(q), 0);

    // Up wrap through 0..9.
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 1, 0);
      check("up_q", int'(q), i % 10);
      check("up_tc", int'(tc), (i == 9) ? 1 : 0);
    end

    // Down wrap from 0.
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 0, 0);
      check("dn_q", int'(q), (10 - i) % 10);
      check("dn_tc", int'(tc), (i == 10) ? 1 : 0);
    end

    // Load beats count; out-of-range load holds and pulses err once.
    cyc(1, 0, 0, 3);
    check("pri_q3", int'(q), 3);
    cyc(1, 1, 1, 6);
    check("pri_q6", int'(q), 6);
    check("pri_err0", int'(err), 0);
    cyc(1, 1, 1, 12);
    check("rng_q", int'(q), 6);
    check("rng_err1", int'(err), 1);
    cyc(0, 0, 1, 0);
    check("rng_err_clr", int'(err), 0);

    // Hold.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0);
      check("hold_q", int'(q), 6);
      check("hold_tc", int'(tc), 0);
    end

    // Direction change at 0 without a dead cycle.
    cyc(1, 0, 1, 0);
    cyc(0, 1, 0, 0);
    check("dir_dn", int'(q), 9);
    cyc(0, 1, 1, 0);
    check("dir_up", int'(q), 0);

    // Full-range modulus wraps by natural overflow.
    cyc(1, 0, 0, 15);
    check("m16_ld15", int'(q16), 15);
    check("m_ld15_err", int'(err), 1);
    cyc(0, 1, 1, 0);
    check("m16_ovf", int'(q16), 0);
    cyc(0, 1, 0, 0);
    check("m16_unf", int'(q16), 15);

    // Reset mid-count leaves nothing pending.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0);
    check("mid_q3", int'(q), 3);
    #2 clrn = 1'b0;
    #1 check("mid_rst_q", int'(q), 0);
    @(negedge clk); #1;
    clrn = 1'b1;
    cyc(0, 1, 1, 0);
    check("mid_rel_q", int'(q), 1);

    // Two-digit cascade.
    cyc(0, 0, 1, 0);
    en_c = 1'b1;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk); #1;
    end
    check("cas_hi99", int'(q_hi), 9);
    check("cas_lo99", int'(q_lo), 9);
    check("cas_tclo", int'(tc_lo), 1);
    check("cas_tchi", int'(tc_hi), 1);
    @(negedge clk); #1;
    check("cas_hi0", int'(q_hi), 0);
    check("cas_lo0", int'(q_lo), 0);
    en_c = 1'b0;
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
